// File: rtl/cu_stream_pkg.sv
// Shared types for the compute-unit scalar output stream: FSM states and FIFO entry layout.
package cu_stream_pkg;

  localparam int unsigned SCALAR_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic                last;
    logic [SCALAR_W-1:0] data;
  } scalar_entry_t;

endpackage

// File: rtl/cu_stream_fifo.sv
// First-word fall-through register FIFO; caller guarantees no push when full and no pop when empty.
module cu_stream_fifo
  import cu_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = scalar_entry_t,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cu_scalar_out_buffer.sv
// Buffers CU scalar results toward the switch, tags run ends, and backpressures the CU.
// Optional occupancy/overflow reporting is built when CU_SCALAR_BUF_OCC_EN is defined.
module cu_scalar_out_buffer
  import cu_stream_pkg::*;
#(
  parameter int unsigned DATA_W = SCALAR_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_enable,
  input  logic [DATA_W-1:0] io_scalarOut,
  input  logic              io_done,
  output logic              io_stall,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_last,
  output logic              io_finished
`ifdef CU_SCALAR_BUF_OCC_EN
  ,
  output logic [CNT_W-1:0]  io_occupancy,
  output logic              io_overflow_sticky
`endif
);

  state_e           state;
  state_e           state_next;
  scalar_entry_t    wr_entry;
  scalar_entry_t    head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;

  assign push     = io_enable & ~io_stall;
  assign pop      = io_out_valid & io_out_ready;
  assign wr_entry = '{last: io_done, data: SCALAR_W'(io_scalarOut)};

  cu_stream_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (scalar_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full)
  );

  assign io_out_valid = (count != '0);
  assign io_out_data  = DATA_W'(head.data);
  assign io_out_last  = head.last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Run sequencing: a pushed last element locks out the CU until it has been popped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = io_done ? DRAIN : STREAM;
      STREAM:  if (push && io_done) state_next = DRAIN;
      DRAIN:   if (pop && head.last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_stall    = full;
    io_finished = 1'b0;
    case (state)
      DRAIN: io_stall = 1'b1;
      DONE: begin
        io_stall    = 1'b1;
        io_finished = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CU_SCALAR_BUF_OCC_EN
  assign io_occupancy = count;

  // Sticky flag for a CU that ignored backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      io_overflow_sticky <= 1'b0;
    else if (io_enable && io_stall) io_overflow_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cu_scalar_out_buffer.sv
// Self-checking bench for cu_scalar_out_buffer: queue-based reference model plus directed scenarios.
module tb_cu_scalar_out_buffer;
  import cu_stream_pkg::*;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              io_enable = 1'b0;
  logic [DATA_W-1:0] io_scalarOut = '0;
  logic              io_done = 1'b0;
  logic              io_out_ready = 1'b0;
  logic              io_stall;
  logic              io_out_valid;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;
  logic              io_finished;
`ifdef CU_SCALAR_BUF_OCC_EN
  logic [CNT_W-1:0]  io_occupancy;
  logic              io_overflow_sticky;
`endif

  int tests = 0;
  int fails = 0;

  cu_scalar_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_scalarOut (io_scalarOut),
    .io_done      (io_done),
    .io_stall     (io_stall),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_out_last  (io_out_last),
    .io_finished  (io_finished)
`ifdef CU_SCALAR_BUF_OCC_EN
    ,
    .io_occupancy       (io_occupancy),
    .io_overflow_sticky (io_overflow_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last,data}, a run-pending flag and a finish pulse.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } m_ent_t;

  m_ent_t q[$];
  bit     draining = 0;
  bit     fin_now  = 0;

  function automatic bit m_stall();
    return (q.size() == DEPTH) || draining || fin_now;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      draining = 0;
      fin_now  = 0;
    end else begin
      bit do_push, do_pop, fin_next;
      do_pop   = (q.size() != 0) && io_out_ready;
      do_push  = io_enable && !m_stall();
      fin_next = 0;
      if (do_pop) begin
        if (q[0].last) begin
          draining = 0;
          fin_next = 1;
        end
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back(m_ent_t'({io_done, io_scalarOut}));
        if (io_done) draining = 1;
      end
      fin_now = fin_next;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("m_stall", 32'(io_stall), 32'(m_stall()));
      chk("m_valid", 32'(io_out_valid), 32'(q.size() != 0));
      chk("m_finished", 32'(io_finished), 32'(fin_now));
      chk("m_count", 32'(dut.u_fifo.count), 32'(q.size()));
      if (q.size() != 0) begin
        chk("m_data", 32'(io_out_data), 32'(q[0].data));
        chk("m_last", 32'(io_out_last), 32'(q[0].last));
      end
`ifdef CU_SCALAR_BUF_OCC_EN
      chk("m_occupancy", 32'(io_occupancy), 32'(q.size()));
`endif
    end
  end

  task automatic drive(input logic en, input logic [DATA_W-1:0] d, input logic dn, input logic rdy);
    @(posedge clk);
    #1;
    io_enable    = en;
    io_scalarOut = d;
    io_done      = dn;
    io_out_ready = rdy;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int fin_cnt;
    bit fin_seen;

    // Reset state
    #1;
    chk("rst_stall", 32'(io_stall), 32'd0);
    chk("rst_valid", 32'(io_out_valid), 32'd0);
    chk("rst_finished", 32'(io_finished), 32'd0);
    mid();
    mid();
    reset = 1'b0;

    // Single-element run
    drive(1'b1, 7'h15, 1'b1, 1'b1);
    mid();
    chk("t1_no_bypass", 32'(io_out_valid), 32'd0);
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    mid();
    chk("t1_valid", 32'(io_out_valid), 32'd1);
    chk("t1_data", 32'(io_out_data), 32'h15);
    chk("t1_last", 32'(io_out_last), 32'd1);
    chk("t1_drain_stall", 32'(io_stall), 32'd1);
    chk("t1_no_fin_yet", 32'(io_finished), 32'd0);
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    mid();
    chk("t1_finished", 32'(io_finished), 32'd1);
    chk("t1_done_stall", 32'(io_stall), 32'd1);
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    mid();
    chk("t1_fin_pulse", 32'(io_finished), 32'd0);
    chk("t1_idle_stall", 32'(io_stall), 32'd0);
    chk("t1_state_idle", 32'(dut.state == IDLE), 32'd1);

    // Fill to full, drop a fifth, pop in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(i + 1), 1'b0, 1'b0);
      mid();
      chk("t2_no_stall", 32'(io_stall), 32'd0);
    end
    drive(1'b1, 7'h05, 1'b0, 1'b0);
    mid();
    chk("t2_full_stall", 32'(io_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 7'h00, 1'b0, 1'b1);
      mid();
      chk("t2_pop_data", 32'(io_out_data), 32'(i + 1));
    end
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t2_empty", 32'(io_out_valid), 32'd0);

    // Full plus pop in the same cycle
    for (int i = 0; i < 4; i++) drive(1'b1, 7'(8'h11 + i), 1'b0, 1'b0);
    drive(1'b1, 7'h7F, 1'b0, 1'b1);
    mid();
    chk("t4_stall", 32'(io_stall), 32'd1);
    chk("t4_head", 32'(io_out_data), 32'h11);
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t4_count3", 32'(dut.u_fifo.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'h00, 1'b0, 1'b1);
      mid();
      chk("t4_rest", 32'(io_out_data), 32'(8'h12 + i));
    end
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t4_empty", 32'(io_out_valid), 32'd0);

    // Steady streaming
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 7'(8'h20 + i), 1'b0, 1'b1);
      mid();
      chk("t3_no_stall", 32'(io_stall), 32'd0);
      if (i > 0) begin
        chk("t3_count1", 32'(dut.u_fifo.count), 32'd1);
        chk("t3_delay1", 32'(io_out_data), 32'(8'h20 + i - 1));
      end
    end
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    mid();
    chk("t3_tail", 32'(io_out_data), 32'h33);
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t3_empty", 32'(io_out_valid), 32'd0);

    // Backpressure during DRAIN
    drive(1'b1, 7'h31, 1'b0, 1'b0);
    drive(1'b1, 7'h32, 1'b0, 1'b0);
    drive(1'b1, 7'h33, 1'b1, 1'b0);
    mid();
    chk("t5_pre_stall", 32'(io_stall), 32'd0);
    pops = 0;
    fin_cnt = 0;
    fin_seen = 0;
    for (int k = 0; k < 12; k++) begin
      drive(!fin_seen, 7'h55, 1'b0, (k % 2) == 0);
      mid();
      if (!fin_seen) chk("t5_stall", 32'(io_stall), 32'd1);
      if (io_out_valid && io_out_ready) begin
        pops++;
        chk("t5_data", 32'(io_out_data), 32'(8'h30 + pops));
        chk("t5_last", 32'(io_out_last), 32'(pops == 3));
      end
      if (io_finished) begin
        fin_cnt++;
        fin_seen = 1;
      end
    end
    chk("t5_pops", 32'(pops), 32'd3);
    chk("t5_fin_once", 32'(fin_cnt), 32'd1);

    // Async reset mid-STREAM
    drive(1'b1, 7'h41, 1'b0, 1'b0);
    drive(1'b1, 7'h42, 1'b0, 1'b0);
    drive(1'b1, 7'h43, 1'b0, 1'b0);
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t6_pre_count", 32'(dut.u_fifo.count), 32'd3);
    chk("t6_pre_valid", 32'(io_out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(io_out_valid), 32'd0);
    chk("t6_async_count", 32'(dut.u_fifo.count), 32'd0);
    chk("t6_async_fin", 32'(io_finished), 32'd0);
    @(posedge clk);
    mid();
    reset = 1'b0;
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    mid();
    chk("t6_fin", 32'(io_finished), 32'd0);
    chk("t6_valid", 32'(io_out_valid), 32'd0);
    chk("t6_stall", 32'(io_stall), 32'd0);
    chk("t6_count", 32'(dut.u_fifo.count), 32'd0);
    chk("t6_state_idle", 32'(dut.state == IDLE), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
